// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage SRAM FSM states and address constants.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } mem_state_t;

    localparam logic [31:0] DATA_BASE_DEF = 32'd1024;

    // Select bit appended to the word index to form the SRAM half-word address.
    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// Two-half-word SRAM access FSM with wait states and a start/done handshake.
// MEM_ADDR_CHECK_EN adds skip_i/err_o so a rejected request goes straight to DONE.
module sram_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              wr_i,
    input  logic [ADDR_W-2:0] widx_i,
    input  logic [31:0]       wdata_i,
`ifdef MEM_ADDR_CHECK_EN
    input  logic              skip_i,
    output logic              err_o,
`endif
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe_o,
    output logic              sram_we_n_o
);

    localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

    mem_state_t        state_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-2:0] widx_q;
    logic [15:0]       whi_q;
    logic [15:0]       lo_q;
    logic [15:0]       dq_q;
    logic              wr_q;
    logic              oe_q;
    logic              we_n_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              skip;
    logic              last;

    assign last = (cnt_q == LAST);

`ifdef MEM_ADDR_CHECK_EN
    logic err_q;
    assign skip  = skip_i;
    assign err_o = err_q;
`else
    assign skip = 1'b0;
`endif

    // Pin registers are loaded on the edge entering LO/HI so they are valid for the whole state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            whi_q   <= '0;
            lo_q    <= '0;
            dq_q    <= '0;
            wr_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
            rdata_q <= '0;
            addr_q  <= '0;
`ifdef MEM_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
`ifdef MEM_ADDR_CHECK_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        widx_q <= widx_i;
                        whi_q  <= wdata_i[31:16];
                        wr_q   <= wr_i;
                        cnt_q  <= '0;
                        if (skip) begin
                            state_q <= DONE;
`ifdef MEM_ADDR_CHECK_EN
                            err_q   <= 1'b1;
`endif
                        end else begin
                            state_q <= LO;
                            addr_q  <= {widx_i, HALF_LO};
                            dq_q    <= wdata_i[15:0];
                            we_n_q  <= ~wr_i;
                            oe_q    <= wr_i;
                        end
                    end
                end
                LO: begin
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= HI;
                        addr_q  <= {widx_q, HALF_HI};
                        dq_q    <= whi_q;
                        if (!wr_q) lo_q <= sram_dq_i;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                HI: begin
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        we_n_q  <= 1'b1;
                        oe_q    <= 1'b0;
                        if (!wr_q) rdata_q <= {sram_dq_i, lo_q};
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    assign done_o       = (state_q == DONE);
    assign rdata_o      = rdata_q;
    assign sram_addr_o  = addr_q;
    assign sram_dq_o    = dq_q;
    assign sram_dq_oe_o = oe_q;
    assign sram_we_n_o  = we_n_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: address mapping, passthroughs and forwarding mux around sram_ctrl.
// MEM_ADDR_CHECK_EN adds addr_err and rejects misaligned or below-base addresses.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF,
    parameter int unsigned ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       st_val,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en_in,
    input  logic [4:0]        dest_in,
    output logic              wb_en_out,
    output logic [4:0]        dest_out,
    output logic              mem_r_en_out,
    output logic [31:0]       alu_result_out,
    output logic [31:0]       mem_result,
    output logic [31:0]       memStVal,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
`ifdef MEM_ADDR_CHECK_EN
    output logic              addr_err,
`endif
    output logic              sram_we_n
);

    logic              req;
    logic              done;
    logic [ADDR_W-2:0] widx;

    assign req  = mem_r_en | mem_w_en;
    assign widx = (ADDR_W-1)'((alu_result - DATA_BASE) >> 2);

`ifdef MEM_ADDR_CHECK_EN
    logic bad_addr;
    assign bad_addr = (alu_result < DATA_BASE) || (alu_result[1:0] != 2'b00);
`endif

    sram_ctrl #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .ADDR_W     (ADDR_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .start_i     (req),
        .wr_i        (mem_w_en),
        .widx_i      (widx),
        .wdata_i     (st_val),
`ifdef MEM_ADDR_CHECK_EN
        .skip_i      (bad_addr),
        .err_o       (addr_err),
`endif
        .done_o      (done),
        .rdata_o     (mem_result),
        .sram_addr_o (sram_addr),
        .sram_dq_o   (sram_dq_out),
        .sram_dq_i   (sram_dq_in),
        .sram_dq_oe_o(sram_dq_oe),
        .sram_we_n_o (sram_we_n)
    );

    assign ready          = ~req | done;
    assign wb_en_out      = wb_en_in;
    assign dest_out       = dest_in;
    assign mem_r_en_out   = mem_r_en;
    assign alu_result_out = alu_result;
    assign memStVal       = mem_r_en ? mem_result : alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (WAIT_CYCLES=1, DATA_BASE=1024) with a 16-bit SRAM model.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en_in;
    logic [4:0]  dest_in;
    logic        wb_en_out;
    logic [4:0]  dest_out;
    logic        mem_r_en_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_result;
    logic [31:0] memStVal;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
`ifdef MEM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    logic [15:0] sram [0:15];

    int          n_checks;
    int          n_pass;
    int          lat;
    int          we_cnt;
    logic [17:0] a_lo;
    logic [17:0] a_hi;
    logic [15:0] d_lo;
    logic [15:0] d_hi;

    mem_stage #(
        .WAIT_CYCLES(1),
        .DATA_BASE  (32'd1024),
        .ADDR_W     (18)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_result    (alu_result),
        .st_val        (st_val),
        .mem_r_en      (mem_r_en),
        .mem_w_en      (mem_w_en),
        .wb_en_in      (wb_en_in),
        .dest_in       (dest_in),
        .wb_en_out     (wb_en_out),
        .dest_out      (dest_out),
        .mem_r_en_out  (mem_r_en_out),
        .alu_result_out(alu_result_out),
        .mem_result    (mem_result),
        .memStVal      (memStVal),
        .ready         (ready),
        .sram_addr     (sram_addr),
        .sram_dq_out   (sram_dq_out),
        .sram_dq_in    (sram_dq_in),
        .sram_dq_oe    (sram_dq_oe),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err      (addr_err),
`endif
        .sram_we_n     (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_we_n) sram[sram_addr[3:0]] <= sram_dq_out;
    end
    assign sram_dq_in = sram[sram_addr[3:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask

    // Launch one instruction in the next cycle and run until ready rises (bounded).
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data);
        @(posedge clk);
        #1;
        mem_r_en   = rd;
        mem_w_en   = wr;
        alu_result = addr;
        st_val     = data;
        wb_en_in   = rd;
        dest_in    = 5'd9;
        lat = 0; we_cnt = 0; a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0;
        #1;
        while (!ready && lat < 40) begin
            if (!sram_we_n) we_cnt++;
            if (lat == 1) begin a_lo = sram_addr; d_lo = sram_dq_out; end
            if (lat == 3) begin a_hi = sram_addr; d_hi = sram_dq_out; end
            @(posedge clk);
            #2;
            lat++;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        rst = 1'b1;
        alu_result = '0; st_val = '0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        wb_en_in = 1'b0; dest_in = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe", sram_dq_oe, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_dq", sram_dq_out, 0);
        check("rst_memres", mem_result, 0);
        check("rst_ready", ready, 1);
`ifdef MEM_ADDR_CHECK_EN
        check("rst_addr_err", addr_err, 0);
`endif
        @(negedge clk) rst = 1'b0;

        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        check("sw_lat", lat, 5);
        check("sw_we_cycles", we_cnt, 4);
        check("sw_addr_lo", a_lo, 2);
        check("sw_addr_hi", a_hi, 3);
        check("sw_dq_lo", d_lo, 32'hBEEF);
        check("sw_dq_hi", d_hi, 32'hDEAD);
        check("sw_memres", mem_result, 0);

        access(1'b1, 1'b0, 32'd1028, 32'h0);
        check("sram2", sram[2], 32'hBEEF);
        check("sram3", sram[3], 32'hDEAD);
        check("lw_lat", lat, 5);
        check("lw_we_cycles", we_cnt, 0);
        check("lw_addr_lo", a_lo, 2);
        check("lw_memres", mem_result, 32'hDEADBEEF);
        check("lw_memstval", memStVal, 32'hDEADBEEF);

        access(1'b0, 1'b0, 32'd7, 32'h0);
        check("add_lat", lat, 0);
        check("add_memstval", memStVal, 7);
        check("add_alu_out", alu_result_out, 7);
        check("add_dest_out", dest_out, 9);
        check("add_memres", mem_result, 32'hDEADBEEF);
        @(posedge clk);
        #2;
        check("add_hold_ready", ready, 1);
        check("add_hold_we_n", sram_we_n, 1);

        // Preload two words, then read them back-to-back.
        access(1'b0, 1'b1, 32'd1024, 32'h22221111);
        access(1'b0, 1'b1, 32'd1032, 32'h44443333);
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        check("b2b0_lat", lat, 5);
        check("b2b0_addr_lo", a_lo, 0);
        check("b2b0_addr_hi", a_hi, 1);
        check("b2b0_memres", mem_result, 32'h22221111);
        access(1'b1, 1'b0, 32'd1032, 32'h0);
        check("b2b1_lat", lat, 5);
        check("b2b1_addr_lo", a_lo, 4);
        check("b2b1_addr_hi", a_hi, 5);
        check("b2b1_memres", mem_result, 32'h44443333);
        check("b2b1_rden_out", mem_r_en_out, 1);

        access(1'b1, 1'b1, 32'd1036, 32'h12345678);
        check("rw_lat", lat, 5);
        check("rw_we_cycles", we_cnt, 4);
        check("rw_memres", mem_result, 32'h44443333);
        access(1'b0, 1'b0, 32'd0, 32'h0);
        check("sram6", sram[6], 32'h5678);
        check("sram7", sram[7], 32'h1234);

`ifdef MEM_ADDR_CHECK_EN
        access(1'b1, 1'b0, 32'd1030, 32'h0);
        check("chk_lat", lat, 1);
        check("chk_err", addr_err, 1);
        check("chk_we_cycles", we_cnt, 0);
        check("chk_memres", mem_result, 32'h44443333);
        access(1'b1, 1'b0, 32'd1020, 32'h0);
        check("chk_low_lat", lat, 1);
        check("chk_low_err", addr_err, 1);
        access(1'b0, 1'b0, 32'd5, 32'h0);
        check("chk_err_clear", addr_err, 0);
`endif

        // Asynchronous reset in the middle of the HI half of a read.
        @(posedge clk);
        #1;
        mem_r_en = 1'b1; mem_w_en = 1'b0; alu_result = 32'd1028;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_hi_addr", sram_addr, 3);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we_n", sram_we_n, 1);
        check("mid_rst_oe", sram_dq_oe, 0);
        check("mid_rst_addr", sram_addr, 0);
        check("mid_rst_memres", mem_result, 0);
        check("mid_rst_ready_req", ready, 0);
        mem_r_en = 1'b0;
        #1;
        check("mid_rst_ready_idle", ready, 1);
        @(negedge clk) rst = 1'b0;

        access(1'b1, 1'b0, 32'd1028, 32'h0);
        check("post_rst_lat", lat, 5);
        check("post_rst_memres", mem_result, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM stage of the 5-stage MIPS pipeline. It consumes the EXE/MEM register outputs (ALU result used as address, store value, control bits) and performs 32-bit lw/sw through an external 16-bit-wide SRAM using two half-word accesses with wait states. While an access is in flight it deasserts ready, which freezes every upstream pipeline register. It passes the write-back controls through to the MEM/WB register and provides the forwarding value memStVal back to EXE.

Parameters:
WAIT_CYCLES, 1, extra SRAM wait cycles per half-word access (0..7)
DATA_BASE, 1024, byte address that maps to SRAM word 0
ADDR_W, 18, SRAM address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
alu_result  in  32  byte address for lw/sw; ALU value for other instructions
st_val  in  32  store data (already forwarded)
mem_r_en  in  1  lw request
mem_w_en  in  1  sw request
wb_en_in  in  1  write-back enable from EXE/MEM
dest_in  in  5  destination register from EXE/MEM
wb_en_out  out  1  passthrough of wb_en_in
dest_out  out  5  passthrough of dest_in
mem_r_en_out  out  1  passthrough (WB mux select)
alu_result_out  out  32  passthrough
mem_result  out  32  assembled read word, held until the next read completes
memStVal  out  32  forwarding value: mem_result if mem_r_en, else alu_result
ready  out  1  0 = freeze pipeline
sram_addr  out  ADDR_W  SRAM half-word address
sram_dq_out  out  16  write data
sram_dq_in  in  16  read data
sram_dq_oe  out  1  1 = drive sram_dq_out onto the bus
sram_we_n  out  1  active-low write strobe

Behaviour:
- Word index: w = (alu_result - DATA_BASE) >> 2. Low half is at SRAM address 2w, high half at 2w+1. The index is truncated to ADDR_W-1 bits.
- req = mem_r_en | mem_w_en. If both are asserted, the access is treated as a write.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: when req is high, latch w, st_val and the write flag, clear the counter, and go to LO.
  - LO: drive sram_addr = 2w. Count 0..WAIT_CYCLES. On the final count, capture sram_dq_in[15:0] into result[15:0] (reads only) and go to HI.
  - HI: the same procedure at address 2w+1, capturing into result[31:16]. Go to DONE.
  - DONE: go to IDLE unconditionally.
- ready = ~req | (state == DONE), combinational.
- Timing: with the request arriving in cycle 0, ready is 0 in cycles 0..2*WAIT_CYCLES+2 and 1 in cycle 2*WAIT_CYCLES+3. For WAIT_CYCLES=1, ready rises in cycle 5.
- Writes: in LO/HI, sram_we_n=0 and sram_dq_oe=1. sram_dq_out carries st_val[15:0] in LO and st_val[31:16] in HI. Otherwise sram_we_n=1 and sram_dq_oe=0.
- mem_result is registered. A read updates it in DONE. It is unchanged by writes and by non-memory instructions.
- Passthrough outputs are combinational and are not gated by ready. The MEM/WB register must not load while ready=0.
- Back-to-back requests: after DONE, IDLE sees the next instruction's req. There is always exactly one IDLE cycle between two accesses.
- If req drops mid-access (illegal, because the pipeline is frozen), the FSM still completes the access. The result is stored but is not flagged.
- Reset (asynchronous, any state): state=IDLE, counter=0, mem_result=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0. ready then follows req.

Optional Feature:
MEM_ADDR_CHECK_EN
- Defined: adds output addr_err (1 bit).
  - A request with alu_result < DATA_BASE, or alu_result[1:0] != 0, skips LO/HI: IDLE goes straight to DONE.
  - No SRAM strobe is issued and mem_result is unchanged.
  - addr_err is high during that DONE cycle and 0 at all other times, including reset.
- Undefined: no addr_err port and no check. The address is used as computed.

Decomposition:
- Shared package mips_pkg:
  - mem_state_t enum (IDLE/LO/HI/DONE)
  - DATA_BASE default
  - half-word select constants
- One natural sub-module, sram_ctrl: the FSM, counter, and SRAM pins, with a start/done handshake.
- mem_stage holds the address mapping, passthroughs, the memStVal mux and the optional check.

Test Plan:
- Reset asserted mid-HI with WAIT_CYCLES=1 -> on the same edge state=IDLE, sram_we_n=1, sram_dq_oe=0, mem_result=0.
- sw with alu_result=1028, st_val=0xDEADBEEF -> SRAM[2]=0xBEEF and SRAM[3]=0xDEAD; ready=0 for cycles 0-4 and 1 in cycle 5.
- lw at 1028 after that sw -> mem_result=0xDEADBEEF in DONE; memStVal=0xDEADBEEF; ready high for exactly one cycle.
- add instruction (mem_r_en=mem_w_en=0, alu_result=7) -> ready=1 the same cycle, memStVal=7, no SRAM strobe.
- Back-to-back lw 1024 then lw 1032 with WAIT_CYCLES=0 -> each access shows ready low for 3 cycles then high for 1, addresses 0,1 then 4,5.
- MEM_ADDR_CHECK_EN defined, lw at 1030 -> DONE one cycle after IDLE, addr_err=1 for one cycle, sram_we_n stays 1, mem_result unchanged.
